// File: rtl/z80_ld_immed_seq.sv
// z80_ld_immed_seq
//
// Sequences the immediate-load instructions LD r,n and LD dd,nn. The opcode and
// its PC arrive from fetch on start. The block reads the one or two operand bytes
// over a req/ack port, then retires in a single COMMIT cycle that writes the
// register file and the new PC together. Any other opcode is rejected with a
// one-cycle illegal/done pulse.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, opcode, pc       instruction hand-off, accepted only while idle
//   flush                   synchronous abort of the in-flight instruction
//   busy                    an instruction is in flight
//   mem_rd_req, mem_addr    operand read request and address
//   mem_rd_ack, mem_rd_data read completion and data, valid in the same cycle
//   reg_wr, reg_wnum,       register-file write; reg_wnum is {0,r} for 8-bit
//   reg_wdata                 registers and 4'b10dd for register pairs
//   pc_wr, pc_wdata         PC update to pc + instruction length
//   done, illegal           retirement pulse; illegal marks a rejected opcode
//
// Optional build macro Z80FI_RETIRE_EN adds the z80fi retirement outputs
// (z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata), valid in COMMIT only.
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally and reset clears all outputs at once.

module z80_ld_immed_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] pc,
    input  logic        flush,
    output logic        busy,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        reg_wr,
    output logic [3:0]  reg_wnum,
    output logic [15:0] reg_wdata,
    output logic        pc_wr,
    output logic [15:0] pc_wdata,
    output logic        done,
    output logic        illegal
`ifdef Z80FI_RETIRE_EN
    ,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_pc_rdata
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchLo,
        StFetchHi,
        StCommit,
        StReject
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q;
    logic        len3_q;
    logic [3:0]  wnum_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
`ifdef Z80FI_RETIRE_EN
    logic [7:0]  opcode_q;
`endif

    logic       is_ld_r;
    logic       is_ld_dd;
    logic       accept;
    logic       commit;
    logic [2:0] len;

    // 00rrr110 with r != 110 (that encoding is LD (HL),n, not handled here).
    assign is_ld_r  = (opcode[7:6] == 2'b00) && (opcode[2:0] == 3'b110) &&
                      (opcode[5:3] != 3'b110);
    assign is_ld_dd = (opcode[7:6] == 2'b00) && (opcode[3:0] == 4'b0001);

    // flush has priority over start, even in idle.
    assign accept = (state_q == StIdle) && start && !flush;
    assign commit = (state_q == StCommit);
    assign len    = len3_q ? 3'd3 : 3'd2;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (is_ld_r || is_ld_dd) ? StFetchLo : StReject;
                end
            end
            StFetchLo: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (mem_rd_ack) begin
                    state_d = len3_q ? StFetchHi : StCommit;
                end
            end
            StFetchHi: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (mem_rd_ack) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            StReject: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= 16'h0000;
            len3_q   <= 1'b0;
            wnum_q   <= 4'h0;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
`ifdef Z80FI_RETIRE_EN
            opcode_q <= 8'h00;
`endif
        end else begin
            if (accept) begin
                pc_q   <= pc;
                len3_q <= is_ld_dd;
                wnum_q <= is_ld_dd ? {2'b10, opcode[5:4]} : {1'b0, opcode[5:3]};
                // Cleared so the unused high byte reads as zero for LD r,n.
                lo_q   <= 8'h00;
                hi_q   <= 8'h00;
`ifdef Z80FI_RETIRE_EN
                opcode_q <= opcode;
`endif
            end
            if ((state_q == StFetchLo) && mem_rd_ack && !flush) begin
                lo_q <= mem_rd_data;
            end
            if ((state_q == StFetchHi) && mem_rd_ack && !flush) begin
                hi_q <= mem_rd_data;
            end
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        mem_rd_req = (state_q == StFetchLo) || (state_q == StFetchHi);
        mem_addr   = 16'h0000;
        if (state_q == StFetchLo) begin
            mem_addr = pc_q + 16'd1;
        end else if (state_q == StFetchHi) begin
            mem_addr = pc_q + 16'd2;
        end
        reg_wr    = commit;
        pc_wr     = commit;
        done      = commit || (state_q == StReject);
        illegal   = (state_q == StReject);
        reg_wnum  = commit ? wnum_q : 4'h0;
        reg_wdata = commit ? {hi_q, lo_q} : 16'h0000;
        pc_wdata  = commit ? (pc_q + {13'd0, len}) : 16'h0000;
    end

`ifdef Z80FI_RETIRE_EN
    always_comb begin
        z80fi_valid    = commit;
        z80fi_insn     = commit ? {8'h00, hi_q, lo_q, opcode_q} : 32'h0;
        z80fi_insn_len = commit ? len : 3'd0;
        z80fi_pc_rdata = commit ? pc_q : 16'h0000;
    end
`endif

endmodule

// File: tb/tb_z80_ld_immed_seq.sv
// Self-checking bench for z80_ld_immed_seq: directed cases, then randomized
// instructions checked cycle by cycle against a reference model of the timeline.
module tb_z80_ld_immed_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  opcode;
    logic [15:0] pc;
    logic        flush;
    logic        busy;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        reg_wr;
    logic [3:0]  reg_wnum;
    logic [15:0] reg_wdata;
    logic        pc_wr;
    logic [15:0] pc_wdata;
    logic        done;
    logic        illegal;
`ifdef Z80FI_RETIRE_EN
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    z80_ld_immed_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .pc          (pc),
        .flush       (flush),
        .busy        (busy),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .reg_wr      (reg_wr),
        .reg_wnum    (reg_wnum),
        .reg_wdata   (reg_wdata),
        .pc_wr       (pc_wr),
        .pc_wdata    (pc_wdata),
        .done        (done),
        .illegal     (illegal)
`ifdef Z80FI_RETIRE_EN
        ,
        .z80fi_valid    (z80fi_valid),
        .z80fi_insn     (z80fi_insn),
        .z80fi_insn_len (z80fi_insn_len),
        .z80fi_pc_rdata (z80fi_pc_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Instruction length from the opcode; 0 means rejected.
    function automatic int len_of(input logic [7:0] op);
        if (((op & 8'hC7) == 8'h06) && (op != 8'h36)) return 2;
        if ((op & 8'hCF) == 8'h01) return 3;
        return 0;
    endfunction

    function automatic logic [3:0] wnum_of(input logic [7:0] op);
        if (len_of(op) == 3) return 4'(8 + ((op >> 4) & 3));
        return 4'((op >> 3) & 7);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_req"}, 32'(mem_rd_req), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_regwr"}, 32'(reg_wr), 0);
        chk({tag, "_wnum"}, 32'(reg_wnum), 0);
        chk({tag, "_wdata"}, 32'(reg_wdata), 0);
        chk({tag, "_pcwr"}, 32'(pc_wr), 0);
        chk({tag, "_pcwdata"}, 32'(pc_wdata), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_illegal"}, 32'(illegal), 0);
`ifdef Z80FI_RETIRE_EN
        chk({tag, "_fivalid"}, 32'(z80fi_valid), 0);
        chk({tag, "_fiinsn"}, z80fi_insn, 0);
`endif
    endtask

    // Issue one instruction and check every cycle until retirement.
    // wlo/whi are wait cycles before each ack; poke pulses start mid-fetch.
    task automatic run(input logic [7:0] op, input logic [15:0] p, input logic [7:0] lo,
                       input logic [7:0] hi, input int wlo, input int whi, input bit poke);
        int          len;
        int          done_cyc;
        int          ph;
        logic [15:0] a_lo;
        logic [15:0] a_hi;
        logic [15:0] pw;
        logic [15:0] wd;
        len      = len_of(op);
        done_cyc = (len == 0) ? 1 : (len == 2) ? 2 + wlo : 3 + wlo + whi;
        a_lo     = p + 16'd1;
        a_hi     = p + 16'd2;
        pw       = p + 16'(len);
        wd       = (len == 3) ? 16'(hi * 256 + lo) : 16'(lo);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        start  = 1'b1;
        opcode = op;
        pc     = p;
        for (int k = 1; k <= done_cyc; k++) begin
            @(negedge clk);
            start       = 1'b0;
            mem_rd_ack  = 1'b0;
            mem_rd_data = 8'($urandom);
            if (len == 0) ph = 0;
            else if (k <= 1 + wlo) ph = 1;
            else if (len == 3 && k <= 2 + wlo + whi) ph = 2;
            else ph = 3;
            chk("busy", 32'(busy), 1);
            chk("req", 32'(mem_rd_req), 32'(ph == 1 || ph == 2));
            if (ph == 1) chk("addr_lo", 32'(mem_addr), 32'(a_lo));
            if (ph == 2) chk("addr_hi", 32'(mem_addr), 32'(a_hi));
            chk("done", 32'(done), 32'(ph == 0 || ph == 3));
            chk("reg_wr", 32'(reg_wr), 32'(ph == 3));
            chk("pc_wr", 32'(pc_wr), 32'(ph == 3));
            chk("illegal", 32'(illegal), 32'(ph == 0));
`ifdef Z80FI_RETIRE_EN
            chk("fi_valid", 32'(z80fi_valid), 32'(ph == 3));
`endif
            if (ph == 3) begin
                chk("wnum", 32'(reg_wnum), 32'(wnum_of(op)));
                chk("wdata", 32'(reg_wdata), 32'(wd));
                chk("pc_wdata", 32'(pc_wdata), 32'(pw));
`ifdef Z80FI_RETIRE_EN
                chk("fi_insn", z80fi_insn, {8'h00, (len == 3) ? hi : 8'h00, lo, op});
                chk("fi_len", 32'(z80fi_insn_len), 32'(len));
                chk("fi_pc", 32'(z80fi_pc_rdata), 32'(p));
`endif
            end
            if (ph == 1 && k == 1 + wlo) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = lo;
            end
            if (ph == 2 && k == 2 + wlo + whi) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = hi;
            end
            if (poke && k == 1 && ph != 3) begin
                start  = 1'b1;
                opcode = 8'h06;
                pc     = 16'hABCD;
            end
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] p;
        int          sel;
        int          r;

        reset_n     = 1'b0;
        start       = 1'b0;
        opcode      = 8'h00;
        pc          = 16'h0000;
        flush       = 1'b0;
        mem_rd_ack  = 1'b0;
        mem_rd_data = 8'h00;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Directed cases.
        run(8'h3E, 16'h0100, 8'h5A, 8'h00, 0, 0, 1'b0);
        run(8'h21, 16'h0100, 8'h34, 8'h12, 2, 2, 1'b0);
        run(8'h36, 16'h0100, 8'h00, 8'h00, 0, 0, 1'b0);
        run(8'h11, 16'h2000, 8'hCD, 8'hAB, 1, 0, 1'b1);
        run(8'h01, 16'hFFFF, 8'h78, 8'h56, 0, 1, 1'b0);
        run(8'h06, 16'hFFFE, 8'h99, 8'h00, 0, 0, 1'b0);

        // Flush while waiting for the second byte; late ack must be ignored.
        @(negedge clk);
        start  = 1'b1;
        opcode = 8'h21;
        pc     = 16'h0200;
        @(negedge clk);
        start = 1'b0;
        chk("fl_req1", 32'(mem_rd_req), 1);
        chk("fl_addr1", 32'(mem_addr), 32'h0201);
        mem_rd_ack  = 1'b1;
        mem_rd_data = 8'h77;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        chk("fl_addr2", 32'(mem_addr), 32'h0202);
        @(negedge clk);
        chk("fl_req3", 32'(mem_rd_req), 1);
        flush  = 1'b1;
        start  = 1'b1;
        opcode = 8'h3E;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk_all_zero("flush");
        mem_rd_ack  = 1'b1;
        mem_rd_data = 8'h55;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        chk_all_zero("late_ack");

        // Asynchronous reset in the middle of FETCH_LO.
        @(negedge clk);
        start  = 1'b1;
        opcode = 8'h3E;
        pc     = 16'h0300;
        @(negedge clk);
        start = 1'b0;
        chk("rst_req_before", 32'(mem_rd_req), 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized instructions, back to back.
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: begin
                    r  = int'($urandom_range(0, 6));
                    if (r == 6) r = 7;
                    op = 8'(r * 8 + 6);
                end
                1: op = 8'($urandom_range(0, 3) * 16 + 1);
                2: op = 8'($urandom);
                default: op = 8'h36;
            endcase
            p = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2))
                                            : 16'($urandom);
            run(op, p, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk_all_zero("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_ld_immed_seq.md
# z80_ld_immed_seq

Sequencer for the Z80 immediate-load datapath: given an already-fetched opcode and its PC, it fetches the one or two immediate operand bytes over a request/acknowledge memory-read port, then commits the register-file write and the new PC in a single retirement cycle. It executes LD r,n (2 bytes) and LD dd,nn (3 bytes), sits between the fetch stage and the register file, and can optionally drive the z80fi retirement signals so the per-instruction formal specs check it directly.

## Interface
Parameters: none.

- clk  in  1  sole clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  opcode valid; accepted only when busy=0
- opcode  in  8  first instruction byte, sampled with start
- pc  in  16  address of the opcode byte, sampled with start
- flush  in  1  synchronous abort of the in-flight instruction
- busy  out  1  instruction in flight (any state except IDLE)
- mem_rd_req  out  1  operand read request
- mem_addr  out  16  operand address, stable while mem_rd_req=1
- mem_rd_ack  in  1  read complete; mem_rd_data valid in the same cycle
- mem_rd_data  in  8  operand byte
- reg_wr  out  1  register-file write strobe, one cycle
- reg_wnum  out  4  {0,r} for 8-bit r; 4'b10dd for pair dd (BC=8, DE=9, HL=10, SP=11)
- reg_wdata  out  16  {8'h00,n} for LD r,n; {hi,lo} for LD dd,nn
- pc_wr  out  1  PC update strobe, coincident with done
- pc_wdata  out  16  opcode pc + instruction length, mod 2^16
- done  out  1  one-cycle retirement pulse
- illegal  out  1  one-cycle pulse; opcode is not handled by this block

## Operation
- Decode at start: 00rrr110 with r≠110 → LD r,n, len 2; 00dd0001 → LD dd,nn, len 3; anything else, including 00110110 → illegal.
- States: IDLE, FETCH_LO, FETCH_HI, COMMIT, REJECT.
- IDLE: on start, latch opcode, pc, and len. Go to FETCH_LO if the opcode is legal, otherwise to REJECT. start is ignored while busy=1.
- FETCH_LO: mem_rd_req=1, mem_addr=pc+1. On ack, capture lo, then go to FETCH_HI (len 3) or COMMIT (len 2).
- FETCH_HI: mem_rd_req=1, mem_addr=pc+2. On ack, capture hi, then go to COMMIT.
- COMMIT: reg_wr=pc_wr=done=1 for exactly one cycle, then go to IDLE.
- REJECT: illegal=done=1, with reg_wr and pc_wr held at 0. Lasts one cycle, then go to IDLE.
- Address arithmetic is 16-bit modular. pc=FFFF fetches from 0000 and 0001, and pc_wdata wraps the same way.
- mem_rd_req stays high until the ack is sampled; the request is never withdrawn except by flush or reset.
- flush in any non-IDLE state: return to IDLE on the next edge with no write, no done, and no illegal. A late ack is ignored. flush in IDLE has no effect. If flush and start are both high, flush wins and start is not accepted.
- Asynchronous reset forces IDLE and drives every output to 0 immediately, including mid-fetch.

## Timing
- Reset values: busy, mem_rd_req, mem_addr, reg_wr, reg_wnum, reg_wdata, pc_wr, pc_wdata, done, illegal are all 0.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- start is accepted at edge 0. mem_rd_req rises in cycle 1.
- With zero-wait acks, done comes in cycle 2 for LD r,n and cycle 3 for LD dd,nn.
- Each wait cycle on an ack adds one cycle of latency.
- For an illegal opcode, done and illegal come in cycle 1.
- A new start is accepted in the cycle after done, so back-to-back instructions are possible.

## Configuration
- Z80FI_RETIRE_EN defined: adds the following outputs:
  - z80fi_valid (=done & ~illegal)
  - z80fi_insn[31:0] ({8'h00, hi, lo, opcode}, unused bytes 0)
  - z80fi_insn_len[2:0]
  - z80fi_pc_rdata[15:0]
  - All are valid in the COMMIT cycle and 0 otherwise, including in reset.
- Z80FI_RETIRE_EN undefined: those ports and their registers are absent. Behaviour is otherwise identical.

## Test plan
- Basic LD r,n: opcode 3E (LD A,n), pc 0100, zero-wait ack returns 5A → read at 0101; reg_wnum 7, reg_wdata 005A, pc_wdata 0102, done in cycle 2.
- LD dd,nn with wait states: opcode 21 (LD HL,nn), data 34 then 12, each ack 2 cycles late → reads at 0101 and 0102; reg_wnum A, reg_wdata 1234, done in cycle 7.
- Illegal and start-while-busy: opcode 36 → illegal=done=1 in cycle 1, no write. Also, start pulsed mid-fetch → ignored, first instruction completes unchanged.
- PC wrap: opcode 01 (LD BC,nn), pc FFFF → mem_addr 0000 then 0001; pc_wdata 0002.
- Abort cases: flush while waiting for the ack of the second byte → IDLE next cycle, no reg_wr or done, and a later ack is ignored. Reset_n low mid-FETCH_LO → mem_rd_req drops immediately and all outputs are 0.
